// File: rtl/rx_8b9b_frame_ctrl.sv
// Frame-level controller for the 8b9b receiver. It gates the receiver enable, buffers one
// frame of words, and hands completed frames downstream via valid/ready with random-access readout.
module rx_8b9b_frame_ctrl #(
    parameter int WORD_WIDTH     = 8,
    parameter int MAX_WORDS      = 16,
    parameter int ADDR_WIDTH     = 4,
    parameter int LEN_WIDTH      = 5,
    parameter int TIMEOUT_CYCLES = 32
) (
    input  logic                  clk,
    input  logic                  sync_reset_n,
    input  logic                  ctrl_enable,
    output logic                  rx_enable,
    input  logic [WORD_WIDTH-1:0] rx_word,
    input  logic                  rx_word_write,
    input  logic                  rx_frame_complete,
    output logic                  frame_valid,
    input  logic                  frame_ready,
    output logic [LEN_WIDTH-1:0]  frame_len,
    input  logic [ADDR_WIDTH-1:0] rd_addr,
    output logic [WORD_WIDTH-1:0] rd_data,
    output logic                  err_overflow,
    output logic                  err_timeout,
    output logic                  err_drop,
    output logic [15:0]           frame_count
);

    localparam int TCNT_WIDTH = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [LEN_WIDTH-1:0]  MAX_LEN   = LEN_WIDTH'(MAX_WORDS);
    localparam logic [TCNT_WIDTH-1:0] TCNT_LAST = TCNT_WIDTH'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ARMED,
        S_RECEIVE,
        S_HOLD
    } state_t;

    logic [WORD_WIDTH-1:0] r_mem [0:(2**ADDR_WIDTH)-1];

    state_t                r_state;
    logic [LEN_WIDTH-1:0]  r_wcnt;
    logic [TCNT_WIDTH-1:0] r_tcnt;
    logic                  r_ovf;
    logic                  r_rx_enable;
    logic                  r_frame_valid;
    logic [LEN_WIDTH-1:0]  r_frame_len;
    logic [WORD_WIDTH-1:0] r_rd_data;
    logic                  r_err_overflow;
    logic                  r_err_timeout;
    logic                  r_err_drop;
    logic [15:0]           r_frame_count;

    logic                  w_full;
    logic                  w_ovf_now;
    logic                  w_timeout;
    logic                  w_wr_en;
    logic [ADDR_WIDTH-1:0] w_wr_addr;

    assign w_full    = (r_wcnt == MAX_LEN);
    // The word that overflows the buffer may itself carry frame_complete, so fold it in.
    assign w_ovf_now = r_ovf | (rx_word_write & w_full);
    assign w_timeout = !rx_word_write && (r_tcnt == TCNT_LAST);
    assign w_wr_en   = rx_word_write &&
                       ((r_state == S_ARMED) || ((r_state == S_RECEIVE) && !w_full));
    assign w_wr_addr = (r_state == S_ARMED) ? '0 : r_wcnt[ADDR_WIDTH-1:0];

    always_ff @(posedge clk) begin
        if (w_wr_en) begin
            r_mem[w_wr_addr] <= rx_word;
        end
    end

    always_ff @(posedge clk) begin
        if (!sync_reset_n) begin
            r_rd_data <= '0;
        end else begin
            r_rd_data <= r_mem[rd_addr];
        end
    end

    always_ff @(posedge clk) begin
        if (!sync_reset_n) begin
            r_state        <= S_IDLE;
            r_wcnt         <= '0;
            r_tcnt         <= '0;
            r_ovf          <= 1'b0;
            r_rx_enable    <= 1'b0;
            r_frame_valid  <= 1'b0;
            r_frame_len    <= '0;
            r_err_overflow <= 1'b0;
            r_err_timeout  <= 1'b0;
            r_err_drop     <= 1'b0;
            r_frame_count  <= '0;
        end else begin
            r_err_overflow <= 1'b0;
            r_err_timeout  <= 1'b0;
            r_err_drop     <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (rx_word_write) begin
                        r_err_drop <= 1'b1;
                    end else if (ctrl_enable) begin
                        r_state     <= S_ARMED;
                        r_rx_enable <= 1'b1;
                    end
                end
                S_ARMED: begin
                    if (rx_word_write) begin
                        r_wcnt      <= LEN_WIDTH'(1);
                        r_tcnt      <= '0;
                        r_ovf       <= 1'b0;
                        r_rx_enable <= 1'b0;
                        if (rx_frame_complete) begin
                            r_state       <= S_HOLD;
                            r_frame_valid <= 1'b1;
                            r_frame_len   <= LEN_WIDTH'(1);
                        end else begin
                            r_state <= S_RECEIVE;
                        end
                    end else if (!ctrl_enable) begin
                        r_state     <= S_IDLE;
                        r_rx_enable <= 1'b0;
                    end
                end
                S_RECEIVE: begin
                    if (rx_word_write) begin
                        r_tcnt <= '0;
                        if (w_full) begin
                            r_ovf <= 1'b1;
                        end else begin
                            r_wcnt <= r_wcnt + LEN_WIDTH'(1);
                        end
                    end else begin
                        r_tcnt <= r_tcnt + TCNT_WIDTH'(1);
                    end
                    // Completion wins over a coincident timeout.
                    if (rx_frame_complete) begin
                        if (w_ovf_now) begin
                            r_err_overflow <= 1'b1;
                            r_ovf          <= 1'b0;
                            r_wcnt         <= '0;
                            r_state        <= ctrl_enable ? S_ARMED : S_IDLE;
                            r_rx_enable    <= ctrl_enable;
                        end else begin
                            r_state       <= S_HOLD;
                            r_frame_valid <= 1'b1;
                            r_frame_len   <= rx_word_write ? (r_wcnt + LEN_WIDTH'(1)) : r_wcnt;
                        end
                    end else if (w_timeout) begin
                        r_err_timeout <= 1'b1;
                        r_wcnt        <= '0;
                        r_ovf         <= 1'b0;
                        r_state       <= ctrl_enable ? S_ARMED : S_IDLE;
                        r_rx_enable   <= ctrl_enable;
                    end
                end
                S_HOLD: begin
                    if (rx_word_write) begin
                        r_err_drop <= 1'b1;
                    end
                    if (frame_ready) begin
                        r_frame_count <= r_frame_count + 16'd1;
                        r_wcnt        <= '0;
                        r_frame_valid <= 1'b0;
                        r_frame_len   <= '0;
                        r_state       <= ctrl_enable ? S_ARMED : S_IDLE;
                        r_rx_enable   <= ctrl_enable;
                    end
                end
                default: begin
                    r_state     <= S_IDLE;
                    r_rx_enable <= 1'b0;
                end
            endcase
        end
    end

    assign rx_enable    = r_rx_enable;
    assign frame_valid  = r_frame_valid;
    assign frame_len    = r_frame_len;
    assign rd_data      = r_rd_data;
    assign err_overflow = r_err_overflow;
    assign err_timeout  = r_err_timeout;
    assign err_drop     = r_err_drop;
    assign frame_count  = r_frame_count;

endmodule

// File: tb/tb_rx_8b9b_frame_ctrl.sv
// Bench for rx_8b9b_frame_ctrl: directed frame scenarios plus randomized traffic,
// every cycle compared against a frame-level behavioural model.
module tb_rx_8b9b_frame_ctrl;

    localparam int MW = 16;
    localparam int TO = 32;

    logic        clk = 1'b0;
    logic        sync_reset_n = 1'b0;
    logic        ctrl_enable = 1'b0;
    logic        rx_enable;
    logic [7:0]  rx_word = '0;
    logic        rx_word_write = 1'b0;
    logic        rx_frame_complete = 1'b0;
    logic        frame_valid;
    logic        frame_ready = 1'b0;
    logic [4:0]  frame_len;
    logic [3:0]  rd_addr = '0;
    logic [7:0]  rd_data;
    logic        err_overflow;
    logic        err_timeout;
    logic        err_drop;
    logic [15:0] frame_count;

    always #5 clk = ~clk;

    rx_8b9b_frame_ctrl #(
        .WORD_WIDTH(8), .MAX_WORDS(MW), .ADDR_WIDTH(4), .LEN_WIDTH(5), .TIMEOUT_CYCLES(TO)
    ) dut (
        .clk(clk), .sync_reset_n(sync_reset_n), .ctrl_enable(ctrl_enable),
        .rx_enable(rx_enable), .rx_word(rx_word), .rx_word_write(rx_word_write),
        .rx_frame_complete(rx_frame_complete), .frame_valid(frame_valid),
        .frame_ready(frame_ready), .frame_len(frame_len), .rd_addr(rd_addr),
        .rd_data(rd_data), .err_overflow(err_overflow), .err_timeout(err_timeout),
        .err_drop(err_drop), .frame_count(frame_count)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Stimulus levels held between cycles.
    bit         g_rstn = 1'b0;
    bit         g_en = 1'b0;
    bit         g_ready = 1'b0;
    bit         g_rd_fixed = 1'b0;
    logic [3:0] g_rd = '0;

    // Model: what the receiver side should look like after the next clock edge.
    bit          m_started = 1'b0;
    bit          m_listen, m_collect, m_hold, m_over, m_rst_seen;
    int          m_idle;
    logic [7:0]  m_words[$];
    logic [7:0]  m_mem[MW];
    bit          m_known[MW];
    logic [15:0] m_count;
    bit          m_rd_known;
    logic [7:0]  m_rd;
    bit          e_ovf, e_to, e_drop;

    task automatic abandon_frame();
        m_collect = 1'b0;
        m_over    = 1'b0;
        m_words.delete();
        m_listen  = ctrl_enable;
    endtask

    task automatic model_step();
        e_ovf = 1'b0; e_to = 1'b0; e_drop = 1'b0; m_rst_seen = 1'b0;
        if (!sync_reset_n) begin
            m_listen = 1'b0; m_collect = 1'b0; m_hold = 1'b0; m_over = 1'b0;
            m_idle = 0; m_words.delete(); m_count = '0;
            m_rd_known = 1'b1; m_rd = '0; m_rst_seen = 1'b1;
            foreach (m_known[i]) m_known[i] = 1'b0;
            return;
        end
        m_rd_known = m_known[rd_addr];
        m_rd       = m_mem[rd_addr];
        if (m_hold) begin
            if (rx_word_write) e_drop = 1'b1;
            if (frame_ready) begin
                m_count++;
                $display("frame %0d delivered: len=%0d first=%02h", m_count, m_words.size(), m_words[0]);
                m_hold = 1'b0;
                m_words.delete();
                m_listen = ctrl_enable;
            end
        end else if (m_collect) begin
            if (rx_word_write) begin
                m_idle = 0;
                if (m_words.size() < MW) begin
                    m_mem[m_words.size()]   = rx_word;
                    m_known[m_words.size()] = 1'b1;
                    m_words.push_back(rx_word);
                end else begin
                    m_over = 1'b1;
                end
            end
            if (rx_frame_complete) begin
                if (m_over) begin
                    e_ovf = 1'b1;
                    $display("frame discarded: overflow");
                    abandon_frame();
                end else begin
                    m_collect = 1'b0;
                    m_hold    = 1'b1;
                end
            end else if (!rx_word_write) begin
                if (m_idle == TO - 1) begin
                    e_to = 1'b1;
                    $display("frame discarded: timeout after %0d words", m_words.size());
                    abandon_frame();
                end else begin
                    m_idle++;
                end
            end
        end else if (m_listen) begin
            if (rx_word_write) begin
                m_mem[0] = rx_word; m_known[0] = 1'b1;
                m_words.delete(); m_words.push_back(rx_word);
                m_idle = 0; m_over = 1'b0; m_listen = 1'b0;
                if (rx_frame_complete) m_hold = 1'b1;
                else m_collect = 1'b1;
            end else if (!ctrl_enable) begin
                m_listen = 1'b0;
            end
        end else begin
            if (rx_word_write) e_drop = 1'b1;
            else if (ctrl_enable) m_listen = 1'b1;
        end
    endtask

    task automatic check_outputs();
        if (!m_started) return;
        check_val("rx_enable", 32'(rx_enable), 32'(m_listen));
        check_val("frame_valid", 32'(frame_valid), 32'(m_hold));
        check_val("err_overflow", 32'(err_overflow), 32'(e_ovf));
        check_val("err_timeout", 32'(err_timeout), 32'(e_to));
        check_val("err_drop", 32'(err_drop), 32'(e_drop));
        check_val("frame_count", 32'(frame_count), 32'(m_count));
        if (m_hold || m_rst_seen)
            check_val("frame_len", 32'(frame_len), m_hold ? 32'(m_words.size()) : 32'd0);
        if (m_rd_known)
            check_val("rd_data", 32'(rd_data), 32'(m_rd));
    endtask

    task automatic cyc(input bit ww, input logic [7:0] w, input bit fc);
        @(negedge clk);
        check_outputs();
        sync_reset_n      = g_rstn;
        ctrl_enable       = g_en;
        frame_ready       = g_ready;
        rx_word_write     = ww;
        rx_word           = w;
        rx_frame_complete = fc;
        rd_addr           = g_rd_fixed ? g_rd : 4'($urandom_range(0, 15));
        model_step();
        m_started = 1'b1;
    endtask

    task automatic wait_listen();
        for (int i = 0; i < 200 && !m_listen; i++) cyc(1'b0, 8'h00, 1'b0);
        if (!m_listen) check_val("arm_wait", 32'(m_listen), 32'd1);
    endtask

    task automatic send_frame(input logic [7:0] words[$], input bit with_fc, input int gap_max);
        wait_listen();
        foreach (words[k]) begin
            if (k > 0) repeat ($urandom_range(0, gap_max)) cyc(1'b0, 8'h00, 1'b0);
            cyc(1'b1, words[k], with_fc && (k == words.size() - 1));
        end
    endtask

    logic [7:0] q[$];

    initial begin
        g_rstn = 1'b0;
        repeat (3) cyc(1'b0, 8'h00, 1'b0);
        g_rstn = 1'b1;
        cyc(1'b0, 8'h00, 1'b0);
        check_val("reset_rx_enable", 32'(rx_enable), 32'd0);
        check_val("reset_rd_data", 32'(rd_data), 32'd0);

        // Two-word frame with immediate release.
        g_en = 1'b1; g_ready = 1'b1;
        q = '{8'hA5, 8'h3C};
        send_frame(q, 1'b1, 0);
        cyc(1'b0, 8'h00, 1'b0);
        g_rd_fixed = 1'b1; g_rd = 4'd0;
        cyc(1'b0, 8'h00, 1'b0);
        g_rd = 4'd1;
        cyc(1'b0, 8'h00, 1'b0);
        check_val("rd_word0", 32'(rd_data), 32'hA5);
        cyc(1'b0, 8'h00, 1'b0);
        check_val("rd_word1", 32'(rd_data), 32'h3C);
        check_val("count_first", 32'(frame_count), 32'd1);
        check_val("rearmed_first", 32'(rx_enable), 32'd1);
        g_rd_fixed = 1'b0;

        // Overflow: 17 words, completion on the last.
        q.delete();
        for (int i = 0; i <= 16; i++) q.push_back(8'(i));
        send_frame(q, 1'b1, 0);
        repeat (3) cyc(1'b0, 8'h00, 1'b0);
        check_val("ovf_count", 32'(frame_count), 32'd1);
        check_val("ovf_rearmed", 32'(rx_enable), 32'd1);

        // Timeout after three words, then a single-word frame.
        q = '{8'h11, 8'h22, 8'h33};
        send_frame(q, 1'b0, 0);
        repeat (34) cyc(1'b0, 8'h00, 1'b0);
        q = '{8'h7E};
        send_frame(q, 1'b1, 0);
        repeat (3) cyc(1'b0, 8'h00, 1'b0);
        check_val("to_count", 32'(frame_count), 32'd2);

        // Backpressure with a stray word while the frame is held.
        g_ready = 1'b0;
        q = '{8'hC1, 8'hC2, 8'hC3, 8'hC4};
        send_frame(q, 1'b1, 2);
        for (int i = 0; i < 100; i++) cyc(i == 50, 8'hEE, 1'b0);
        check_val("bp_len", 32'(frame_len), 32'd4);
        g_ready = 1'b1;
        repeat (3) cyc(1'b0, 8'h00, 1'b0);

        // Disable mid-frame: frame still delivered, then idle.
        wait_listen();
        cyc(1'b1, 8'h51, 1'b0);
        cyc(1'b1, 8'h52, 1'b0);
        g_en = 1'b0;
        cyc(1'b1, 8'h53, 1'b0);
        cyc(1'b1, 8'h54, 1'b1);
        repeat (4) cyc(1'b0, 8'h00, 1'b0);
        check_val("dis_count", 32'(frame_count), 32'd4);
        check_val("dis_idle", 32'(rx_enable), 32'd0);

        // Reset in the middle of a frame.
        g_en = 1'b1;
        q = '{8'h61, 8'h62};
        send_frame(q, 1'b0, 0);
        g_rstn = 1'b0;
        cyc(1'b0, 8'h00, 1'b0);
        g_rstn = 1'b1;
        cyc(1'b0, 8'h00, 1'b0);
        check_val("rst_count", 32'(frame_count), 32'd0);
        check_val("rst_valid", 32'(frame_valid), 32'd0);
        check_val("rst_timeout", 32'(err_timeout), 32'd0);

        // Randomized traffic.
        for (int c = 0; c < 3000; c++) begin
            bit ww, fc;
            g_rstn  = ($urandom % 400) != 0;
            g_en    = ($urandom % 10) != 0;
            g_ready = ($urandom % 3) == 0;
            if (((c / 500) % 2) == 0) ww = ($urandom % 2) == 0;
            else ww = ($urandom % 25) == 0;
            fc = ww ? (($urandom % 16) == 0) : (($urandom % 50) == 0);
            cyc(ww, 8'($urandom), fc);
        end
        cyc(1'b0, 8'h00, 1'b0);
        @(negedge clk);
        check_outputs();

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
